// File: rtl/cordic_sqrt_pkg.sv
// Shared definitions for the CORDIC square-root front end (prenormalizer) and
// the downstream denormalizer.
package cordic_sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sqrt_state_e;

  // Width needed to hold a pair-shift count of 0..dsize/2.
  function automatic int unsigned sqrt_shift_width(input int unsigned dsize);
    return $clog2(dsize / 2 + 1);
  endfunction

endpackage

// File: rtl/cordic_sqrt_prenorm.sv
// Normalizes an unsigned fraction into [0.25,1) by left shifts in pairs, so the
// square root of the result only needs a plain right shift to denormalize.
module cordic_sqrt_prenorm
  import cordic_sqrt_pkg::*;
#(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned SW    = sqrt_shift_width(DSIZE)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] dn,
  output logic [SW-1:0]    shift,
  output logic             zero
);

  generate
    if ((DSIZE < 4) || (DSIZE % 2 != 0)) begin : g_bad_dsize
      $error("cordic_sqrt_prenorm: DSIZE must be even and at least 4");
    end
  endgenerate

  sqrt_state_e      state_q, state_d;
  logic [DSIZE-1:0] work_q;
  logic [SW-1:0]    count_q;
  logic             lead_nz;
  logic             work_zero;
  logic             norm_done;

  assign lead_nz   = |work_q[DSIZE-1:DSIZE-2];
  assign work_zero = (work_q == '0);
  assign norm_done = lead_nz || work_zero;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (norm_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= d;
            count_q <= '0;
          end
        end
        SHIFT: begin
          // A nonzero work value reaches the top pair within DSIZE/2-1 shifts,
          // so count cannot exceed that bound.
          if (!norm_done) begin
            work_q  <= {work_q[DSIZE-3:0], 2'b00};
            count_q <= count_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dn        = out_valid ? work_q  : '0;
  assign shift     = out_valid ? count_q : '0;
  assign zero      = out_valid && work_zero;

endmodule

// File: tb/tb_cordic_sqrt_prenorm.sv
// Scoreboard bench for cordic_sqrt_prenorm: random fractions against a
// leading-one based reference, plus handshake, stall and reset scenarios.
module tb_cordic_sqrt_prenorm;

  localparam int DSIZE = 16;
  localparam int SW    = 4;

  logic             clock;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] dn;
  logic [SW-1:0]    shift;
  logic             zero;

  cordic_sqrt_prenorm #(.DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dn        (dn),
    .shift     (shift),
    .zero      (zero)
  );

  typedef struct {
    logic [DSIZE-1:0] dn;
    int               shift;
    bit               zero;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   hold_low = 0;
  bit   holding  = 0;
  bit   expect_idle = 0;
  logic [DSIZE-1:0] h_dn;
  logic [SW-1:0]    h_shift;
  logic             h_zero;

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: normalize by the position of the leading one, rounded to pairs.
  function automatic exp_t model(input logic [DSIZE-1:0] x);
    exp_t e;
    int msb = -1;
    for (int i = 0; i < DSIZE; i++) if (x[i]) msb = i;
    e.acc = 0;
    if (x == 0) begin
      e.dn = '0; e.shift = 0; e.zero = 1;
    end else begin
      e.shift = (DSIZE - 1 - msb) / 2;
      e.dn    = x << (2 * e.shift);
      e.zero  = 0;
    end
    return e;
  endfunction

  initial begin
    out_ready = 0;
    forever begin
      @(posedge clock); #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      holding = 0;
      expect_idle = 0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_dn", int'(dn), 0);
      chk("rst_shift", int'(shift), 0);
      chk("rst_zero", int'(zero), 0);
    end else begin
      if (expect_idle) begin
        chk("in_ready_after_accept", int'(in_ready), 1);
        chk("out_valid_after_accept", int'(out_valid), 0);
        expect_idle = 0;
      end
      if (out_valid) begin
        chk("in_ready_low_in_done", int'(in_ready), 0);
        if (!holding) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_out_valid actual=1 expected=0 dn=0x%0h (cycle %0d)", dn, cyc);
          end else begin
            e = sb.pop_front();
            chk("dn", int'(dn), int'(e.dn));
            chk("shift", int'(shift), e.shift);
            chk("zero", int'(zero), int'(e.zero));
            chk("latency", cyc - e.acc, e.shift + 1);
          end
          holding = 1;
          h_dn = dn; h_shift = shift; h_zero = zero;
        end else begin
          chk("hold_dn", int'(dn), int'(h_dn));
          chk("hold_shift", int'(shift), int'(h_shift));
          chk("hold_zero", int'(zero), int'(h_zero));
        end
        if (out_ready) begin
          holding = 0;
          expect_idle = 1;
        end
      end
    end
  end

  // Issue one item, then poke garbage on in_valid/d until the block is idle again.
  task automatic send(input logic [DSIZE-1:0] x);
    exp_t e;
    int t = 0;
    e = model(x);
    in_valid = 1; d = x;
    while (!in_ready && t < 200) begin @(posedge clock); #1; t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 expected=1");
      in_valid = 0;
      return;
    end
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clock); #1;
    t = 0;
    while (!in_ready && t < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      d = DSIZE'($urandom);
      @(posedge clock); #1; t++;
    end
    in_valid = 0;
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL complete_timeout in_ready actual=0 expected=1");
    end
  endtask

  task automatic stall_ctrl();
    int t = 0;
    while (!out_valid && t < 50) begin @(posedge clock); #1; t++; end
    repeat (5) @(posedge clock);
    #1 hold_low = 0;
  endtask

  initial begin
    logic [DSIZE-1:0] x;
    int t;
    rst_n = 0; in_valid = 0; d = '0;
    repeat (3) @(posedge clock);
    #1 rst_n = 1;

    send(16'hE666);
    send(16'h0800);
    send(16'h0001);
    send(16'h0000);
    send(16'hC000);
    send(16'h3FFF);

    hold_low = 1; out_ready = 0;
    fork
      send(16'h0100);
      stall_ctrl();
    join

    // Abandon an item with an asynchronous reset during its third SHIFT cycle.
    in_valid = 1; d = 16'h0001;
    @(posedge clock); #1;
    in_valid = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    rst_n = 1;
    send(16'h4000);
    repeat (10) @(posedge clock);

    for (int n = 0; n < 150; n++) begin
      x = DSIZE'($urandom);
      x = x >> $urandom_range(0, DSIZE);
      send(x);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    t = 0;
    while (sb.size() != 0 && t < 200) begin @(posedge clock); t++; end
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
